digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised digit-serial adder with carry-in and carry-out. It extends our fixed two-bit ripple slices to any operand width and processes DIGIT bits per clock, least-significant digit first, through a registered carry. The block sits between operand producers and consumers that trade latency for area, and uses a valid/ready handshake on both sides.

## Interface

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits added per clock; 1 ≤ DIGIT ≤ WIDTH.
- NDIG is derived as WIDTH/DIGIT. The digit counter is max(1, clog2(NDIG)) bits wide.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept an operand set; high only in IDLE.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- cin  input  1  carry-in, sampled on accept.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result bits [WIDTH-1:0] of a+b+cin.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  signed overflow. This port exists only with DSA_OVF_EN.

## Operation

- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE.
- IDLE → RUN on an edge where in_valid&&in_ready is true (the accept edge).
  - a and b load into shift registers.
  - cin loads into the carry register.
  - The digit counter clears to 0.
- RUN, one edge per digit:
  - {c, s} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry, computed (DIGIT+1) bits wide.
  - carry ← c.
  - a_sh and b_sh shift right by DIGIT.
  - The sum register shifts right by DIGIT, and s enters at bits [WIDTH-1:WIDTH-DIGIT].
  - The counter increments. On the edge where the counter equals NDIG-1, state goes to DONE, and cout and out_valid are set.
- DONE → IDLE on the edge where out_ready is high. out_valid clears on that edge.
- in_valid outside IDLE is ignored. The operands are not captured.
- sum, cout and ovf hold stable from entry to DONE until the DONE → IDLE edge. They also keep their values in IDLE until the next result is produced.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry out.
- Degenerate case DIGIT==WIDTH: RUN lasts exactly one edge.

## Timing

- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, state IDLE, counter 0, carry 0.
- Latency: the accept edge is E0, and out_valid is high after edge E_NDIG. That is NDIG edges, or 8 for the defaults.
- Throughput: with out_ready held high, one operation per NDIG+2 cycles.
  - E0: accept.
  - E_NDIG: enter DONE.
  - E_NDIG+1: handshake, enter IDLE.
  - E_NDIG+2: next accept.
- in_ready and busy are decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Reset asserted at any edge, including mid-RUN or in DONE with a pending result:
  - the operation is aborted;
  - all outputs return to their reset values after that edge;
  - no out_valid pulse follows.
- No pipelining or overlap: a new accept cannot happen in the same edge as the DONE handshake.

## Configuration

- DSA_OVF_EN defined:
  - The ovf port is present.
  - On the edge entering DONE, ovf is set to (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), evaluated on the original operands and the final sum. The operand MSBs are held in a 2-bit register at accept.
  - ovf holds and resets like sum.
- DSA_OVF_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan

- Defaults, a=0x00FF, b=0x0001, cin=0 → sum=0x0100, cout=0, out_valid high exactly 8 edges after accept, in_ready low during that time.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1 (DSA_OVF_EN build).
- Backpressure: out_ready low for 5 cycles in DONE → out_valid, sum and cout stay constant and in_ready stays 0. Raise out_ready → out_valid drops after one edge, and in_ready=1.
- Reset mid-op: drop rst_n for one edge on the 3rd RUN edge → next cycle state IDLE, in_ready=1, out_valid=0, sum=0. No later out_valid pulse.
- in_valid held high with changing a/b while busy → those values are ignored. The result matches the operands sampled at accept. Back-to-back accepts are spaced exactly NDIG+2 edges with out_ready tied high.
- WIDTH=8, DIGIT=8, a=0x80, b=0x80, cin=1 → sum=0x01, cout=1, ovf=1, latency 1 edge. WIDTH=8, DIGIT=1 → latency 8 edges with the same result.

Source files
------------

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder.
// The ovf signal is present only when DSA_OVF_EN is defined.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef DSA_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side: offers operands and takes the result.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef DSA_OVF_EN
        , input ovf
`endif
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef DSA_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock, LSD first, through a registered carry.
// Optional signed-overflow output enabled by defining DSA_OVF_EN.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    digit_serial_adder_if.slave io
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             last_s;
    logic [DIGIT:0]   digit_sum_s;
    logic [WIDTH-1:0] sum_next_s;
`ifdef DSA_OVF_EN
    logic [1:0]       msb_r;
    logic             ovf_r;
`endif

    // Handshake decode and the per-digit add/shift datapath.
    always_comb begin
        accept_s    = 1'b0;
        last_s      = 1'b0;
        digit_sum_s = {1'b0, a_sh_r[DIGIT-1:0]} + {1'b0, b_sh_r[DIGIT-1:0]}
                      + (DIGIT+1)'(carry_r);
        // New digit enters at the top so the LSD ends up at bit 0 after NDIG steps.
        sum_next_s  = (sum_sh_r >> DIGIT)
                      | (WIDTH'(digit_sum_s[DIGIT-1:0]) << (WIDTH - DIGIT));
        if (state_r == IDLE) begin
            accept_s = io.in_valid;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == RUN) begin
            last_s = (cnt_r == CW'(NDIG - 1));
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = RUN;
                else          next_state_s = IDLE;
            end
            RUN: begin
                if (last_s) next_state_s = DONE;
                else        next_state_s = RUN;
            end
            DONE: begin
                if (io.out_ready) next_state_s = IDLE;
                else              next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Operand capture, serial stepping and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= '0;
            carry_r     <= 1'b0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            sum_sh_r    <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef DSA_OVF_EN
            msb_r       <= 2'b00;
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_sh_r  <= io.a;
                        b_sh_r  <= io.b;
                        carry_r <= io.cin;
                        cnt_r   <= '0;
`ifdef DSA_OVF_EN
                        msb_r   <= {io.a[WIDTH-1], io.b[WIDTH-1]};
`endif
                    end
                end
                RUN: begin
                    carry_r  <= digit_sum_s[DIGIT];
                    a_sh_r   <= a_sh_r >> DIGIT;
                    b_sh_r   <= b_sh_r >> DIGIT;
                    sum_sh_r <= sum_next_s;
                    cnt_r    <= cnt_r + CW'(1);
                    // Visible result only changes here, so it holds through DONE and IDLE.
                    if (last_s) begin
                        sum_r       <= sum_next_s;
                        cout_r      <= digit_sum_s[DIGIT];
                        out_valid_r <= 1'b1;
`ifdef DSA_OVF_EN
                        ovf_r       <= (msb_r[1] == msb_r[0])
                                       && (sum_next_s[WIDTH-1] != msb_r[1]);
`endif
                    end
                end
                DONE: begin
                    if (io.out_ready) out_valid_r <= 1'b0;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign io.in_ready  = (state_r == IDLE);
    assign io.busy      = (state_r == RUN) || (state_r == DONE);
    assign io.out_valid = out_valid_r;
    assign io.sum       = sum_r;
    assign io.cout      = cout_r;
`ifdef DSA_OVF_EN
    assign io.ovf       = ovf_r;
`endif
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench: default 16/2 instance plus 8/8 and 8/1 corner instances.
module tb_digit_serial_adder;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    digit_serial_adder_if #(.WIDTH(16)) if16 ();
    digit_serial_adder_if #(.WIDTH(8))  if88 ();
    digit_serial_adder_if #(.WIDTH(8))  if81 ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(2)) u16 (.clk(clk), .rst_n(rst_n), .io(if16.slave));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) u88 (.clk(clk), .rst_n(rst_n), .io(if88.slave));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) u81 (.clk(clk), .rst_n(rst_n), .io(if81.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One 16-bit operation; hold = cycles of backpressure before out_ready.
    task automatic run16(input string nm, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic ec, input int hold);
        int   lat;
        logic bad;
        if16.a = va;
        if16.b = vb;
        if16.cin = vc;
        if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        if16.a = ~va;
        if16.b = ~vb;
        lat = 0;
        bad = 1'b0;
        while (!if16.out_valid && lat < 20) begin
            if (if16.in_ready !== 1'b0 || if16.busy !== 1'b1) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd8);
        chk({nm, " ready_low_in_run"}, 32'(bad), 32'd0);
        chk({nm, " sum"}, 32'(if16.sum), 32'(es));
        chk({nm, " cout"}, 32'(if16.cout), 32'(ec));
        bad = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (if16.out_valid !== 1'b1 || if16.sum !== es || if16.cout !== ec
                || if16.in_ready !== 1'b0) bad = 1'b1;
        end
        if (hold > 0) chk({nm, " backpressure_hold"}, 32'(bad), 32'd0);
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        if16.out_ready = 1'b0;
        chk({nm, " out_valid_after_hs"}, 32'(if16.out_valid), 32'd0);
        chk({nm, " in_ready_after_hs"}, 32'(if16.in_ready), 32'd1);
        chk({nm, " sum_held_idle"}, 32'(if16.sum), 32'(es));
    endtask

    initial begin : main
        int   lat88;
        int   lat81;
        int   nacc;
        int   nres;
        int   acc_at[2];
        logic [15:0] pa[2];
        logic [15:0] pb[2];
        logic [15:0] ps[2];
        logic seen;

        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        rst_n = 1'b0;
        {if16.in_valid, if16.cin, if16.out_ready} = 3'b000;
        {if88.in_valid, if88.cin, if88.out_ready} = 3'b000;
        {if81.in_valid, if81.cin, if81.out_ready} = 3'b000;
        if16.a = 16'h0; if16.b = 16'h0;
        if88.a = 8'h0;  if88.b = 8'h0;
        if81.a = 8'h0;  if81.b = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset in_ready", 32'(if16.in_ready), 32'd1);
        chk("reset out_valid", 32'(if16.out_valid), 32'd0);
        chk("reset busy", 32'(if16.busy), 32'd0);
        chk("reset sum", 32'(if16.sum), 32'd0);
        chk("reset cout", 32'(if16.cout), 32'd0);
`ifdef DSA_OVF_EN
        chk("reset ovf", 32'(if16.ovf), 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            run16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].sum, vecs[i].cout, 0);
`ifdef DSA_OVF_EN
            chk($sformatf("vec%0d ovf", i), 32'(if16.ovf), 32'(vecs[i].ovf));
`endif
        end

        // 0x1357 + 0x2468 = 0x37BF, consumer stalls 5 cycles.
        run16("bp", 16'h1357, 16'h2468, 1'b0, 16'h37BF, 1'b0, 5);

        // Abort on the 3rd RUN edge; no result may appear afterwards.
        if16.a = 16'hFFFF; if16.b = 16'h0001; if16.cin = 1'b0;
        if16.in_valid = 1'b1;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort in_ready", 32'(if16.in_ready), 32'd1);
        chk("abort out_valid", 32'(if16.out_valid), 32'd0);
        chk("abort busy", 32'(if16.busy), 32'd0);
        chk("abort sum", 32'(if16.sum), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if16.out_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort no_late_valid", 32'(seen), 32'd0);

        // in_valid held, operands change while busy, out_ready tied high.
        pa[0] = 16'h0F0F; pb[0] = 16'h0101; ps[0] = 16'h1010;
        pa[1] = 16'h3000; pb[1] = 16'h0FFF; ps[1] = 16'h3FFF;
        acc_at[0] = -1; acc_at[1] = -1;
        nacc = 0;
        nres = 0;
        if16.cin = 1'b0;
        if16.out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (if16.out_valid === 1'b1) begin
                if (nres < 2) chk($sformatf("b2b sum%0d", nres), 32'(if16.sum), 32'(ps[nres]));
                nres++;
            end
            if (if16.in_ready === 1'b1) begin
                if (nacc < 2) begin
                    if16.in_valid = 1'b1;
                    if16.a = pa[nacc];
                    if16.b = pb[nacc];
                    acc_at[nacc] = i;
                    nacc++;
                end else begin
                    if16.in_valid = 1'b0;
                end
            end else begin
                if16.in_valid = 1'b1;
                if16.a = 16'($urandom);
                if16.b = 16'($urandom);
            end
            @(posedge clk); #1;
        end
        if16.in_valid = 1'b0;
        if16.out_ready = 1'b0;
        chk("b2b results", 32'(nres), 32'd2);
        chk("b2b spacing", 32'(acc_at[1] - acc_at[0]), 32'd10);

        // 0x80 + 0x80 + 1 on the 8-bit builds.
        if88.a = 8'h80; if88.b = 8'h80; if88.cin = 1'b1; if88.in_valid = 1'b1;
        if81.a = 8'h80; if81.b = 8'h80; if81.cin = 1'b1; if81.in_valid = 1'b1;
        @(posedge clk); #1;
        if88.in_valid = 1'b0;
        if81.in_valid = 1'b0;
        lat88 = -1;
        lat81 = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (lat88 < 0 && if88.out_valid === 1'b1) lat88 = e;
            if (lat81 < 0 && if81.out_valid === 1'b1) lat81 = e;
        end
        // Edges are counted from E0; the first loop edge is E1.
        chk("w8d8 latency", 32'(lat88), 32'd1);
        chk("w8d1 latency", 32'(lat81), 32'd8);
        chk("w8d8 sum", 32'(if88.sum), 32'h01);
        chk("w8d8 cout", 32'(if88.cout), 32'd1);
        chk("w8d1 sum", 32'(if81.sum), 32'h01);
        chk("w8d1 cout", 32'(if81.cout), 32'd1);
`ifdef DSA_OVF_EN
        chk("w8d8 ovf", 32'(if88.ovf), 32'd1);
        chk("w8d1 ovf", 32'(if81.ovf), 32'd1);
`endif
        if88.out_ready = 1'b1;
        if81.out_ready = 1'b1;
        @(posedge clk); #1;
        if88.out_ready = 1'b0;
        if81.out_ready = 1'b0;
        chk("w8d8 out_valid_after_hs", 32'(if88.out_valid), 32'd0);
        chk("w8d1 in_ready_after_hs", 32'(if81.in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
